// File: rtl/imem_loader.sv
// Boot loader for the 64x32 instruction memory: assembles big-endian words from a
// byte stream, writes them sequentially, then hands the address port to the PC.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [6:0]        word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] imem_a,
    output logic              imem_we,
    output logic [DATA_W-1:0] imem_wd,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic [6:0]        loaded_words
);

    localparam int BYTES = DATA_W / 8;
    localparam int SH_W  = DATA_W - 8;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [6:0]        target_q, target_d;
    logic [6:0]        loaded_q, loaded_d;
    logic              hs;
    logic              last_word;

    assign hs        = in_valid && (state_q == LOAD);
    assign last_word = (loaded_q + 7'd1) == target_q;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        wd_d       = wd_q;
        target_d   = target_q;
        loaded_d   = loaded_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d   = (word_count == 7'd0) ? 7'(DEPTH) : word_count;
                    wr_addr_d  = '0;
                    byte_idx_d = '0;
                    loaded_d   = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (hs) begin
                    shift_d    = {shift_q[SH_W-9:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'(BYTES - 1)) begin
                        wd_d       = {shift_q, in_data};
                        byte_idx_d = '0;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                loaded_d = loaded_q + 7'd1;
                if (last_word) begin
                    // Address stays on the final word so a full load never wraps to 0.
                    state_d = DONE;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    state_d   = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            wd_q       <= '0;
            target_q   <= '0;
            loaded_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            wd_q       <= wd_d;
            target_q   <= target_d;
            loaded_q   <= loaded_d;
        end
    end

    // Control outputs are pure decodes of the state register; only imem_a muxes an input.
    assign in_ready     = (state_q == LOAD);
    assign imem_we      = (state_q == WRITE);
    assign busy         = (state_q == LOAD) || (state_q == WRITE);
    assign done         = (state_q == DONE);
    assign cpu_rst_n    = (state_q == DONE);
    assign imem_wd      = wd_q;
    assign loaded_words = loaded_q;

    always_comb begin
        imem_a = '0;
        case (state_q)
            DONE:        imem_a = pc_addr;
            LOAD, WRITE: imem_a = wr_addr_q;
            default:     imem_a = '0;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-stream model predicts each write's
// address, data and cycle, plus the handoff state after each load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [5:0]  pc_addr;
    logic [5:0]  imem_a;
    logic        imem_we;
    logic [31:0] imem_wd;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic [6:0]  loaded_words;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] stim [256];

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pc_addr(pc_addr), .imem_a(imem_a), .imem_we(imem_we), .imem_wd(imem_wd),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .loaded_words(loaded_words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int k);
        return {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
    endfunction

    task automatic fill_random(input int nbytes);
        for (int i = 0; i < nbytes; i++) stim[i] = 8'($urandom);
    endtask

    // Runs one full load from IDLE/DONE; gap_pct drops in_valid at random,
    // hold_byte stalls 3 cycles before that byte, poke_start pulses start mid-load.
    task automatic run_load(input int wc, input int gap_pct, input int hold_byte,
                            input bit poke_start);
        int nw, nb, acc, wr, cyc, budget, hold_cnt;
        int exp_cyc[$];
        nw = (wc == 0) ? 64 : wc;
        nb = 4 * nw;
        budget = nb * 20 + 50;
        acc = 0; wr = 0; cyc = 1; hold_cnt = 0;
        @(negedge clk);
        start = 1'b1; word_count = 7'(wc);
        @(negedge clk);
        start = 1'b0;
        chk("ld_entry", {29'd0, in_ready, done, cpu_rst_n}, 32'b100);
        while (wr < nw && cyc < budget) begin
            if (imem_we) begin
                chk("we_addr", 32'(imem_a), wr);
                chk("we_data", imem_wd, word_of(wr));
                chk("we_rdy", 32'(in_ready), 0);
                if (exp_cyc.size() == 0) chk("we_cyc_extra", cyc, 0);
                else chk("we_cyc", cyc, exp_cyc.pop_front());
                wr++;
            end
            chk("ld_flags", {29'd0, busy, cpu_rst_n, done}, 32'b100);
            pc_addr = 6'($urandom);
            start = (poke_start && cyc == 3) ? 1'b1 : 1'b0;
            word_count = 7'($urandom);
            if (acc < nb && acc == hold_byte && hold_cnt < 3) begin
                in_valid = 1'b0; in_data = 8'($urandom); hold_cnt++;
            end else if (acc < nb && int'($urandom_range(99)) >= gap_pct) begin
                in_valid = 1'b1; in_data = stim[acc];
            end else begin
                in_valid = 1'b0; in_data = 8'($urandom);
            end
            if (in_valid && in_ready) begin
                if (acc % 4 == 3) exp_cyc.push_back(cyc + 1);
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("ld_writes", wr, nw);
        in_valid = 1'b0; start = 1'b0;
        chk("dn_flags", {27'd0, done, cpu_rst_n, busy, in_ready, imem_we}, 32'b11000);
        chk("dn_count", 32'(loaded_words), nw);
        chk("dn_wd_hold", imem_wd, word_of(nw - 1));
        pc_addr = 6'($urandom);
        #1 chk("dn_amux", 32'(imem_a), 32'(pc_addr));
    endtask

    initial begin
        logic [7:0] t2 [8];
        logic [7:0] t4 [4];
        t2 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
        t4 = '{8'hAC, 8'h03, 8'h00, 8'h08};
        rst_n = 1'b0; start = 1'b0; word_count = '0; in_valid = 1'b0;
        in_data = '0; pc_addr = 6'd17;

        // Reset values, then idle with no start.
        #12;
        chk("rst_flags", {25'd0, in_ready, imem_we, cpu_rst_n, busy, done, 2'b00}, 0);
        chk("rst_wd", imem_wd, 0);
        chk("rst_a", 32'(imem_a), 0);
        chk("rst_cnt", 32'(loaded_words), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_cpu_rst", 32'(cpu_rst_n), 0);
        chk("idle_a", 32'(imem_a), 0);
        chk("idle_rdy", 32'(in_ready), 0);

        // Two-word program, streamed back to back.
        for (int i = 0; i < 8; i++) stim[i] = t2[i];
        run_load(2, 0, -1, 1'b0);
        chk("t2_w0", word_of(0), 32'h20080005);

        // Same program with a 3-cycle stall before byte 2.
        run_load(2, 0, 2, 1'b0);

        // Reload from DONE with start poked mid-load.
        @(negedge clk); pc_addr = 6'd5;
        #1 chk("t4_amux", 32'(imem_a), 5);
        chk("t4_we", 32'(imem_we), 0);
        for (int i = 0; i < 4; i++) stim[i] = t4[i];
        run_load(1, 0, -1, 1'b1);

        // Reset after 2 bytes of word 0.
        @(negedge clk); start = 1'b1; word_count = 7'd3;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk); in_data = 8'h22;
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("abort_flags", {27'd0, imem_we, busy, cpu_rst_n, done, in_ready}, 0);
        chk("abort_cnt", 32'(loaded_words), 0);
        chk("abort_wd", imem_wd, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {30'd0, busy, imem_we}, 0);
        fill_random(12);
        run_load(3, 20, -1, 1'b0);

        // Random loads.
        for (int n = 0; n < 6; n++) begin
            int wc;
            wc = int'($urandom_range(1, 20));
            fill_random(4 * wc);
            run_load(wc, 30, int'($urandom_range(0, 4 * wc - 1)), n[0]);
        end

        // Full 64-word load, then an extra byte that must be refused.
        fill_random(256);
        run_load(0, 10, -1, 1'b0);
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_extra", {30'd0, in_ready, imem_we}, 0);
            chk("full_cnt", 32'(loaded_words), 64);
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
